// File: rtl/store_retire_buffer_pkg.sv
// Shared definitions for the store retire buffer and the completion stage that feeds it:
// widths, the store-entry field slices, and the drain FSM encoding.
package store_retire_buffer_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int INST_W   = ADDR_W + DATA_W;
    localparam int SB_DEPTH = 8;

    // Completed store layout: {data, addr}
    localparam int ST_ADDR_LO = 0;
    localparam int ST_ADDR_HI = ADDR_W - 1;
    localparam int ST_DATA_LO = ADDR_W;
    localparam int ST_DATA_HI = INST_W - 1;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_e;

    function automatic logic [ADDR_W-1:0] st_addr(input logic [INST_W-1:0] inst);
        return inst[ST_ADDR_HI:ST_ADDR_LO];
    endfunction

    function automatic logic [DATA_W-1:0] st_data(input logic [INST_W-1:0] inst);
        return inst[ST_DATA_HI:ST_DATA_LO];
    endfunction

endpackage

// File: rtl/store_retire_buffer_if.sv
// Bus bundle between completion, the store retire buffer, data memory and the load lookup port.
// Handshakes: completion may present stores only while sb_ready=1 (pushes when it is 0 are dropped
// and flagged); dmem_req holds addr/wdata stable until the cycle dmem_ack=1 retires the head entry.
interface store_retire_buffer_if;
    import store_retire_buffer_pkg::*;

    logic [INST_W-1:0] completed_inst_0;
    logic [INST_W-1:0] completed_inst_1;
    logic              completed_inst_0_valid;
    logic              completed_inst_1_valid;
    logic              sb_ready;
    logic              dmem_req;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              sb_empty;
    logic              sb_overflow;

    modport slave (
        input  completed_inst_0, completed_inst_1, completed_inst_0_valid, completed_inst_1_valid,
        input  dmem_ack, ld_addr,
        output sb_ready, dmem_req, dmem_addr, dmem_wdata, ld_hit, ld_data, sb_empty, sb_overflow
    );

    modport master (
        output completed_inst_0, completed_inst_1, completed_inst_0_valid, completed_inst_1_valid,
        output dmem_ack, ld_addr,
        input  sb_ready, dmem_req, dmem_addr, dmem_wdata, ld_hit, ld_data, sb_empty, sb_overflow
    );

endinterface

// File: rtl/store_retire_buffer_fwd_match.sv
// Store-to-load forwarding: full-address compare against every valid entry, youngest match wins,
// where age is measured backward from tail-1 with wrap.
module sb_fwd_match
    import store_retire_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [DEPTH-1:0][DATA_W-1:0] datas,
    input  logic [$clog2(DEPTH)-1:0]     tail,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last (youngest) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (valid[idx] && (addrs[idx] == ld_addr)) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/store_retire_buffer.sv
// In-order store retire buffer: accepts up to two completed stores per cycle into a circular FIFO,
// drains them one at a time to data memory, and forwards buffered data to load lookups.
module store_retire_buffer
    import store_retire_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    store_retire_buffer_if.slave     bus,
    output drain_state_e             fsm_state,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic                         overflow;
    drain_state_e                 state;
    drain_state_e                 state_next;

    logic             push0;
    logic             push1;
    logic             pop;
    logic [1:0]       n_push;
    logic [PTR_W-1:0] slot1_idx;

    assign bus.sb_ready = (DEPTH_CNT - count) >= (PTR_W+1)'(2);

    // A lone slot-1 store lands at tail, so no hole is left behind it.
    assign push0     = bus.completed_inst_0_valid & bus.sb_ready;
    assign push1     = bus.completed_inst_1_valid & bus.sb_ready;
    assign slot1_idx = tail + PTR_W'(push0);
    assign n_push    = {1'b0, push0} + {1'b0, push1};
    assign pop       = (state == DRAIN_REQ) & bus.dmem_ack;

    always_ff @(posedge clk) begin
        if (push0) begin
            addr_mem[tail] <= st_addr(bus.completed_inst_0);
            data_mem[tail] <= st_data(bus.completed_inst_0);
        end
        if (push1) begin
            addr_mem[slot1_idx] <= st_addr(bus.completed_inst_1);
            data_mem[slot1_idx] <= st_data(bus.completed_inst_1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            valid    <= '0;
            overflow <= 1'b0;
            state    <= DRAIN_IDLE;
        end else begin
            if (pop)   valid[head]      <= 1'b0;
            if (push0) valid[tail]      <= 1'b1;
            if (push1) valid[slot1_idx] <= 1'b1;
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(n_push);
            count <= count + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);
            if ((bus.completed_inst_0_valid | bus.completed_inst_1_valid) & ~bus.sb_ready)
                overflow <= 1'b1;
            state <= state_next;
        end
    end

    // The head entry stays presented until its ack edge; leave REQ only when that was the last one.
    always_comb begin
        state_next     = state;
        bus.dmem_req   = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        case (state)
            DRAIN_IDLE: begin
                if (count != '0) state_next = DRAIN_REQ;
            end
            DRAIN_REQ: begin
                bus.dmem_req   = 1'b1;
                bus.dmem_addr  = addr_mem[head];
                bus.dmem_wdata = data_mem[head];
                if (bus.dmem_ack && (count == (PTR_W+1)'(1))) state_next = DRAIN_IDLE;
            end
            default: state_next = DRAIN_IDLE;
        endcase
    end

    assign bus.sb_empty    = (count == '0) & ~bus.dmem_req;
    assign bus.sb_overflow = overflow;
    assign fsm_state       = state;

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .valid   (valid),
        .addrs   (addr_mem),
        .datas   (data_mem),
        .tail    (tail),
        .ld_addr (bus.ld_addr),
        .hit     (bus.ld_hit),
        .data    (bus.ld_data)
    );

endmodule

// File: tb/tb_store_retire_buffer.sv
// Bench for store_retire_buffer: directed sequences, a forwarding vector table, and random traffic
// scored against a queue model of the buffered stores.
module tb_store_retire_buffer;
  import store_retire_buffer_pkg::*;

  localparam int DEPTH = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_retire_buffer_if sif();
  drain_state_e fsm_state;
  logic [3:0] count;

  store_retire_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sif),
    .fsm_state (fsm_state),
    .count     (count)
  );

  // scoreboard: buffered stores oldest first, each {data, addr}
  logic [63:0] exp_q[$];
  logic m_ovf;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] ld;
    logic        hit;
    logic [31:0] data;
  } fwd_vec_t;
  fwd_vec_t fwd_tab[6];

  logic [31:0] drained[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] d1);
    sif.completed_inst_0_valid = v0;
    sif.completed_inst_0 = {d0, a0};
    sif.completed_inst_1_valid = v1;
    sif.completed_inst_1 = {d1, a1};
  endtask

  task automatic idle_in();
    sif.completed_inst_0_valid = 1'b0;
    sif.completed_inst_1_valid = 1'b0;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic cycle();
    int sz;
    logic m_ready, m_hit, do_pop, pv0, pv1;
    logic [31:0] m_data;
    logic [63:0] i0, i1;
    #1;
    sz = exp_q.size();
    m_ready = (DEPTH - sz) >= 2;
    chk("ready", sif.sb_ready, m_ready);
    chk("count", count, sz);
    chk("overflow", sif.sb_overflow, m_ovf);
    chk("empty", sif.sb_empty, (sz == 0) && !sif.dmem_req);
    if (sz == 0) chk("req_when_empty", sif.dmem_req, 0);
    else if (sif.dmem_req) begin
      chk("dmem_addr", sif.dmem_addr, exp_q[0][31:0]);
      chk("dmem_wdata", sif.dmem_wdata, exp_q[0][63:32]);
    end
    m_hit = 1'b0;
    m_data = '0;
    for (int i = 0; i < sz; i++) begin
      if (exp_q[i][31:0] == sif.ld_addr) begin
        m_hit = 1'b1;
        m_data = exp_q[i][63:32];
      end
    end
    chk("ld_hit", sif.ld_hit, m_hit);
    if (m_hit) chk("ld_data", sif.ld_data, m_data);
    do_pop = sif.dmem_req && sif.dmem_ack && (sz > 0);
    pv0 = sif.completed_inst_0_valid;
    pv1 = sif.completed_inst_1_valid;
    i0 = sif.completed_inst_0;
    i1 = sif.completed_inst_1;
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (pv0 || pv1) begin
      if (m_ready) begin
        if (pv0) exp_q.push_back(i0);
        if (pv1) exp_q.push_back(i1);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain_all(input string name);
    int n;
    sif.dmem_ack = 1'b1;
    idle_in();
    n = 0;
    while ((exp_q.size() > 0 || sif.dmem_req) && n < 40) begin
      if (sif.dmem_req) drained.push_back(sif.dmem_addr);
      cycle();
      n++;
    end
    #1;
    chk({name, "_drain_done"}, sif.sb_empty, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd_tab[0] = '{32'h300, 1'b1, 32'h22};
    fwd_tab[1] = '{32'h304, 1'b0, 32'h0};
    fwd_tab[2] = '{32'h308, 1'b1, 32'h55};
    fwd_tab[3] = '{32'h310, 1'b1, 32'h66};
    fwd_tab[4] = '{32'h30C, 1'b0, 32'h0};
    fwd_tab[5] = '{32'h000, 1'b0, 32'h0};

    idle_in();
    sif.completed_inst_0 = '0;
    sif.completed_inst_1 = '0;
    sif.dmem_ack = 1'b0;
    sif.ld_addr = '0;
    m_ovf = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", sif.dmem_req, 0);
    chk("rst_addr", sif.dmem_addr, 0);
    chk("rst_wdata", sif.dmem_wdata, 0);
    chk("rst_ready", sif.sb_ready, 1);
    chk("rst_empty", sif.sb_empty, 1);
    chk("rst_overflow", sif.sb_overflow, 0);
    chk("rst_hit", sif.ld_hit, 0);
    chk("rst_ld_data", sif.ld_data, 0);
    chk("rst_count", count, 0);
    chk("rst_state", fsm_state, DRAIN_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (10) begin
      #1;
      chk("t1_req", sif.dmem_req, 0);
      cycle();
    end

    // 2: dual push, ack tied high, in-order drain
    sif.dmem_ack = 1'b1;
    drive(1, 32'h100, 32'hAAAA0001, 1, 32'h104, 32'hBBBB0002);
    cycle();
    idle_in();
    #1;
    chk("t2_latency_req", sif.dmem_req, 0);
    chk("t2_count", count, 2);
    cycle();
    #1;
    chk("t2_req0", sif.dmem_req, 1);
    chk("t2_addr0", sif.dmem_addr, 32'h100);
    chk("t2_data0", sif.dmem_wdata, 32'hAAAA0001);
    cycle();
    #1;
    chk("t2_req1", sif.dmem_req, 1);
    chk("t2_addr1", sif.dmem_addr, 32'h104);
    chk("t2_data1", sif.dmem_wdata, 32'hBBBB0002);
    cycle();
    #1;
    chk("t2_empty", sif.sb_empty, 1);
    chk("t2_req_off", sif.dmem_req, 0);

    // 3: slot-1-only push
    drive(0, 32'h0, 32'h0, 1, 32'h200, 32'hC);
    cycle();
    idle_in();
    #1;
    chk("t3_count", count, 1);
    cycle();
    #1;
    chk("t3_req", sif.dmem_req, 1);
    chk("t3_addr", sif.dmem_addr, 32'h200);
    chk("t3_data", sif.dmem_wdata, 32'hC);
    cycle();
    #1;
    chk("t3_empty", sif.sb_empty, 1);

    // 4: fill with ack low, overflow, then drain across the wrap
    sif.dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h400 + 8 * i, 32'hD00 + 2 * i, 1, 32'h404 + 8 * i, 32'hD01 + 2 * i);
      cycle();
    end
    idle_in();
    #1;
    chk("t4_ready_full", sif.sb_ready, 0);
    chk("t4_count_full", count, 8);
    drive(1, 32'h4F0, 32'hEE, 1, 32'h4F4, 32'hEF);
    cycle();
    idle_in();
    #1;
    chk("t4_overflow", sif.sb_overflow, 1);
    chk("t4_count_held", count, 8);
    drained.delete();
    drain_all("t4");
    chk("t4_drain_len", drained.size(), 8);
    for (int i = 0; i < 8 && i < drained.size(); i++)
      chk("t4_drain_order", drained[i], 32'h400 + 4 * i);

    // 5: forwarding table, six entries wrapping past index 7, ack low
    sif.dmem_ack = 1'b0;
    drive(1, 32'h300, 32'h11, 1, 32'h300, 32'h22);
    cycle();
    drive(0, 32'h0, 32'h0, 1, 32'h308, 32'h33);
    cycle();
    drive(1, 32'h310, 32'h44, 1, 32'h308, 32'h55);
    cycle();
    drive(1, 32'h310, 32'h66, 0, 32'h0, 32'h0);
    cycle();
    idle_in();
    cycle();
    #1;
    chk("t5_head_req", sif.dmem_req, 1);
    for (int i = 0; i < 6; i++) begin
      sif.ld_addr = fwd_tab[i].ld;
      #1;
      chk("t5_fwd_hit", sif.ld_hit, fwd_tab[i].hit);
      if (fwd_tab[i].hit) chk("t5_fwd_data", sif.ld_data, fwd_tab[i].data);
    end
    sif.ld_addr = 32'h0;
    @(negedge clk);
    drain_all("t5");

    // 6: reset in the middle of a request
    sif.dmem_ack = 1'b0;
    drive(1, 32'h600, 32'h1, 1, 32'h604, 32'h2);
    cycle();
    drive(1, 32'h608, 32'h3, 0, 32'h0, 32'h0);
    cycle();
    idle_in();
    #1;
    chk("t6_req_before", sif.dmem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_dropped", sif.dmem_req, 0);
    chk("t6_overflow_clr", sif.sb_overflow, 0);
    exp_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_count", count, 0);
    chk("t6_empty", sif.sb_empty, 1);
    repeat (3) cycle();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), 32'h700 + 4 * $urandom_range(0, 5), $urandom,
            $urandom_range(0, 1), 32'h700 + 4 * $urandom_range(0, 5), $urandom);
      sif.dmem_ack = ($urandom_range(0, 3) != 0);
      sif.ld_addr = 32'h700 + 4 * $urandom_range(0, 6);
      cycle();
    end
    drain_all("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
